cfg_lut_chain: RTL and testbench



---
 rtl/cfg_lut_chain_if.sv | 21 ++
 rtl/cfg_lut_chain.sv | 144 ++++++++++++++
 tb/tb_cfg_lut_chain.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cfg_lut_chain_if.sv
// Configuration stream interface for cfg_lut_chain.
// The master drives the serial valid/ready load stream; the slave (the LUT chain) returns status.
interface cfg_lut_chain_if;
  logic cfg_start;
  logic cfg_abort;
  logic cfg_valid;
  logic cfg_data;
  logic cfg_ready;
  logic cfg_done;
  logic cfg_busy;

  modport master (
    output cfg_start, cfg_abort, cfg_valid, cfg_data,
    input  cfg_ready, cfg_done, cfg_busy
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_valid, cfg_data,
    output cfg_ready, cfg_done, cfg_busy
  );
endinterface

// File: rtl/cfg_lut_chain.sv
// Cascade of runtime-configurable 2-input LUT stages, each with an optional output register.
// Configuration is shifted serially into a shadow chain and committed atomically.
module cfg_lut_chain #(
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in0,
  input  logic [NUM_STAGES-1:0] side_in,
  output logic                  out0,
  output logic [NUM_STAGES-1:0] stage_out,
  cfg_lut_chain_if.slave        cfg
);

  localparam int unsigned CFG_BITS = 5 * NUM_STAGES;
  localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [CFG_BITS-1:0]   r_shadow;
  logic [CFG_BITS-1:0]   r_active;
  logic [NUM_STAGES-1:0] r_pipe;
  logic [NUM_STAGES-1:0] w_lut_vec;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_busy;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_commit;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state and per-cycle control decode
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg.cfg_start && !cfg.cfg_abort) begin
          w_next_state = S_LOAD;
          w_start      = 1'b1;
        end
      end
      S_LOAD: begin
        // Abort takes priority over a coincident data beat
        if (cfg.cfg_abort) begin
          w_next_state = S_IDLE;
        end else if (cfg.cfg_valid) begin
          w_accept = 1'b1;
          if (w_cnt_inc == CNT_W'(CFG_BITS)) begin
            w_next_state = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        w_commit     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == S_LOAD);
      r_done  <= (w_next_state == S_COMMIT);
      r_busy  <= (w_next_state == S_LOAD) || (w_next_state == S_COMMIT);
    end
  end

  // Bit counter, shadow shift chain and atomic commit into the active config
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (w_start) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_accept) begin
        r_shadow <= {r_shadow[CFG_BITS-2:0], cfg.cfg_data};
      end
      if (w_commit) begin
        r_active <= r_shadow;
      end
    end
  end

  // Stage registers capture every cycle; the REG bit only selects the tap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= w_lut_vec;
    end
  end

  for (genvar i = 0; i < int'(NUM_STAGES); i++) begin : g_stage
    logic       w_a;
    logic       w_lut;
    logic       w_out;
    logic       w_reg;
    logic [3:0] w_tt;

    if (i == 0) begin : g_first
      assign w_a = in0;
    end else begin : g_next
      assign w_a = g_stage[i-1].w_out;
    end

    assign w_tt         = r_active[5*i +: 4];
    assign w_reg        = r_active[5*i + 4];
    assign w_lut        = w_tt[{side_in[i], w_a}];
    assign w_out        = w_reg ? r_pipe[i] : w_lut;
    assign w_lut_vec[i] = w_lut;
    assign stage_out[i] = w_out;
  end

  assign out0          = stage_out[NUM_STAGES-1];
  assign cfg.cfg_ready = r_ready;
  assign cfg.cfg_done  = r_done;
  assign cfg.cfg_busy  = r_busy;

endmodule

// File: tb/tb_cfg_lut_chain.sv
// Directed bench for a two-stage cfg_lut_chain: vector table for the AND/XOR
// configuration plus hand sequences for load, gaps, abort, pipelining and reset.
module tb_cfg_lut_chain;

  typedef struct packed {
    logic       in0;
    logic [1:0] side;
    logic [1:0] exp_so;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       in0;
  logic [1:0] side_in;
  logic       out0;
  logic [1:0] stage_out;

  int n_total;
  int n_pass;

  vec_t tbl [8];

  localparam logic [9:0] STR_ANDXOR = 10'b0011001000;
  localparam logic [9:0] STR_PIPE   = 10'b1011011000;
  localparam logic [9:0] STR_ONES   = 10'b1111111111;

  cfg_lut_chain_if cfg_if ();

  cfg_lut_chain #(.NUM_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0       (in0),
    .side_in   (side_in),
    .out0      (out0),
    .stage_out (stage_out),
    .cfg       (cfg_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic apply_table(input string nm);
    for (int v = 0; v < 8; v++) begin
      in0     = tbl[v].in0;
      side_in = tbl[v].side;
      #1;
      chk($sformatf("%s stage_out v%0d", nm, v), 32'(stage_out), 32'(tbl[v].exp_so));
      chk($sformatf("%s out0 v%0d", nm, v), 32'(out0), 32'(tbl[v].exp_so[1]));
    end
    @(negedge clk);
  endtask

  // Full ten-bit session; checks handshake flags and the cfg_done pulse position/width
  task automatic load(input logic [9:0] s, input bit gapped, input string nm);
    int pre  = 0;
    int post = 0;
    int last = 0;
    cfg_if.cfg_start = 1'b1;
    @(negedge clk);
    cfg_if.cfg_start = 1'b0;
    chk({nm, " ready"}, 32'(cfg_if.cfg_ready), 32'd1);
    chk({nm, " busy"}, 32'(cfg_if.cfg_busy), 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (gapped) begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = ~s[9-k];
        @(negedge clk);
        if (cfg_if.cfg_done) pre++;
      end
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = s[9-k];
      @(negedge clk);
      if (k == 9) last = int'(cfg_if.cfg_done);
      else if (cfg_if.cfg_done) pre++;
    end
    cfg_if.cfg_valid = 1'b0;
    chk({nm, " ready in commit"}, 32'(cfg_if.cfg_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cfg_if.cfg_done) post++;
    end
    chk({nm, " done early"}, 32'(pre), 32'd0);
    chk({nm, " done after last bit"}, 32'(last), 32'd1);
    chk({nm, " done width"}, 32'(post), 32'd0);
    chk({nm, " busy after"}, 32'(cfg_if.cfg_busy), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    tbl[0] = '{1'b0, 2'b00, 2'b00};
    tbl[1] = '{1'b0, 2'b01, 2'b00};
    tbl[2] = '{1'b0, 2'b10, 2'b10};
    tbl[3] = '{1'b0, 2'b11, 2'b10};
    tbl[4] = '{1'b1, 2'b00, 2'b00};
    tbl[5] = '{1'b1, 2'b01, 2'b11};
    tbl[6] = '{1'b1, 2'b10, 2'b10};
    tbl[7] = '{1'b1, 2'b11, 2'b01};

    reset            = 1'b1;
    in0              = 1'b0;
    side_in          = 2'b00;
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_abort = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state: all LUTs output zero
    in0     = 1'b1;
    side_in = 2'b11;
    @(negedge clk);
    chk("rst out0", 32'(out0), 32'd0);
    chk("rst stage_out", 32'(stage_out), 32'd0);
    chk("rst ready", 32'(cfg_if.cfg_ready), 32'd0);
    chk("rst busy", 32'(cfg_if.cfg_busy), 32'd0);
    chk("rst done", 32'(cfg_if.cfg_done), 32'd0);

    load(STR_ANDXOR, 1'b0, "load1");
    apply_table("andxor1");

    // Both stages registered: latency of two cycles
    load(STR_PIPE, 1'b0, "pipe");
    in0     = 1'b0;
    side_in = 2'b01;
    repeat (3) @(negedge clk);
    in0 = 1'b1;
    #1;
    chk("pipe cycle0", 32'(stage_out), 32'd0);
    @(negedge clk);
    chk("pipe cycle1", 32'(stage_out), 32'b01);
    chk("pipe out0 cycle1", 32'(out0), 32'd0);
    @(negedge clk);
    chk("pipe cycle2", 32'(stage_out), 32'b11);
    chk("pipe out0 cycle2", 32'(out0), 32'd1);

    load(STR_ANDXOR, 1'b1, "gapped");
    apply_table("andxor_gapped");

    // Abort coinciding with what would be the final bit: no commit
    cfg_if.cfg_start = 1'b1;
    @(negedge clk);
    cfg_if.cfg_start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = STR_ONES[9-k];
      @(negedge clk);
    end
    cfg_if.cfg_abort = 1'b1;
    cfg_if.cfg_data  = 1'b1;
    @(negedge clk);
    cfg_if.cfg_abort = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    chk("abort ready", 32'(cfg_if.cfg_ready), 32'd0);
    chk("abort busy", 32'(cfg_if.cfg_busy), 32'd0);
    begin
      int dn = 0;
      for (int k = 0; k < 3; k++) begin
        if (cfg_if.cfg_done) dn++;
        @(negedge clk);
      end
      chk("abort no done", 32'(dn), 32'd0);
    end
    apply_table("after_abort");
    load(STR_PIPE, 1'b0, "post_abort");

    // Reset in the middle of a load
    cfg_if.cfg_start = 1'b1;
    @(negedge clk);
    cfg_if.cfg_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = STR_ONES[9-k];
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset            = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    in0              = 1'b1;
    side_in          = 2'b11;
    #1;
    chk("midrst out0", 32'(out0), 32'd0);
    chk("midrst stage_out", 32'(stage_out), 32'd0);
    chk("midrst busy", 32'(cfg_if.cfg_busy), 32'd0);
    chk("midrst ready", 32'(cfg_if.cfg_ready), 32'd0);
    load(STR_ANDXOR, 1'b0, "after_rst");
    apply_table("andxor_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
